// File: rtl/hbm_tg_pkg.sv
// Shared types and AXI constants for the HBM AXI traffic master.
package hbm_tg_pkg;

    localparam int unsigned DATA_W     = 512;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned PAT_W      = 32;
    localparam int unsigned PAGE_BEATS = 64;

    localparam logic [2:0] AXI_SIZE_64B      = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    // Latched burst request, shared by AW and AR
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } ax_req_t;

endpackage

// File: rtl/hbm_axi_traffic_master_if.sv
// AXI4 bus between the traffic master and the HBM S00_AXI slave port.
interface hbm_axi_traffic_master_if;
    import hbm_tg_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [31:0]       awuser;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic [63:0]       wuser;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [31:0]       aruser;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/hbm_tg_pattern_gen.sv
// Beat data generator: the seed plus beat index, replicated across the data bus.
module hbm_tg_pattern_gen
    import hbm_tg_pkg::*;
(
    input  logic [PAT_W-1:0]  seed,
    input  logic [7:0]        beat,
    output logic [DATA_W-1:0] data_c
);

    logic [PAT_W-1:0] word;

    assign word   = seed + PAT_W'(beat);
    assign data_c = {(DATA_W / PAT_W){word}};

endmodule

// File: rtl/hbm_axi_traffic_master.sv
// Single-burst write/read-back/compare AXI4 initiator for HBM bring-up and BIST.
module hbm_axi_traffic_master
    import hbm_tg_pkg::*;
#(
    parameter logic [ID_W-1:0] AXI_ID         = 4'h0,
    parameter int unsigned     MAX_BEATS      = 64,
    parameter int unsigned     TIMEOUT_CYCLES = 4096
) (
    input  logic                      aclk_0,
    input  logic                      aresetn_0,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [8:0]                num_beats_i,
    input  logic [31:0]               seed_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_cfg_o,
    output logic                      err_resp_o,
    output logic                      err_proto_o,
    output logic                      timeout_o,
    output logic [15:0]               mismatch_cnt_o,
    output logic [7:0]                first_bad_beat_o,
    hbm_axi_traffic_master_if.master  m00_axi
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    ax_req_t            req_q, req_d;
    logic [PAT_W-1:0]   seed_q, seed_d;
    logic [7:0]         beat_q, beat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DATA_W-1:0]  pat_q, pat_d;
    logic               err_cfg_d, err_resp_d, err_proto_d, timeout_d;
    logic [15:0]        mis_d;
    logic [7:0]         first_bad_d;
    logic               awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
    logic               hs, last_beat, cfg_bad;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^base_addr_i[5:0];

    // Reject empty, oversized or 4 KB-crossing bursts before any traffic
    assign cfg_bad = (num_beats_i == 9'd0) || (num_beats_i > 9'(MAX_BEATS)) ||
                     ((10'(base_addr_i[11:6]) + 10'(num_beats_i)) > 10'(PAGE_BEATS));
    assign last_beat = (beat_q == req_q.len);

    // pat_q always holds the pattern for beat_q: W data and the R compare reference
    hbm_tg_pattern_gen u_pattern_gen (
        .seed   (seed_d),
        .beat   (beat_d),
        .data_c (pat_d)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        seed_d      = seed_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        err_cfg_d   = err_cfg_o;
        err_resp_d  = err_resp_o;
        err_proto_d = err_proto_o;
        timeout_d   = timeout_o;
        mis_d       = mismatch_cnt_o;
        first_bad_d = first_bad_beat_o;
        hs          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    req_d.addr  = {base_addr_i[ADDR_W-1:6], 6'b0};
                    req_d.len   = 8'(num_beats_i - 9'd1);
                    seed_d      = seed_i;
                    beat_d      = 8'd0;
                    err_cfg_d   = cfg_bad;
                    err_resp_d  = 1'b0;
                    err_proto_d = 1'b0;
                    timeout_d   = 1'b0;
                    mis_d       = 16'd0;
                    first_bad_d = 8'hFF;
                    state_d     = cfg_bad ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (awvalid_q && m00_axi.awready) begin
                    hs      = 1'b1;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (wvalid_q && m00_axi.wready) begin
                    hs = 1'b1;
                    if (last_beat) begin
                        beat_d  = 8'd0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_B: begin
                if (bready_q && m00_axi.bvalid) begin
                    hs = 1'b1;
                    if (m00_axi.bresp != AXI_RESP_OKAY) err_resp_d = 1'b1;
                    if (m00_axi.bid != AXI_ID)          err_proto_d = 1'b1;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (arvalid_q && m00_axi.arready) begin
                    hs      = 1'b1;
                    beat_d  = 8'd0;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rready_q && m00_axi.rvalid) begin
                    hs = 1'b1;
                    if (m00_axi.rdata != pat_q) begin
                        if (mismatch_cnt_o != 16'hFFFF) mis_d = mismatch_cnt_o + 16'd1;
                        if (first_bad_beat_o == 8'hFF)  first_bad_d = beat_q;
                    end
                    if (m00_axi.rresp != AXI_RESP_OKAY) err_resp_d = 1'b1;
                    if ((m00_axi.rid != AXI_ID) || (m00_axi.rlast != last_beat)) err_proto_d = 1'b1;
                    if (last_beat) begin
                        beat_d  = 8'd0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Stall watchdog: flags only, the transaction is never abandoned
        if ((state_d != state_q) || hs || (state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            tmo_d = '0;
        end else begin
            if (tmo_q != TMO_W'(TIMEOUT_CYCLES))     tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge aclk_0) begin
        if (!aresetn_0) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            seed_q           <= '0;
            beat_q           <= '0;
            tmo_q            <= '0;
            pat_q            <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_cfg_o        <= 1'b0;
            err_resp_o       <= 1'b0;
            err_proto_o      <= 1'b0;
            timeout_o        <= 1'b0;
            mismatch_cnt_o   <= '0;
            first_bad_beat_o <= 8'hFF;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            wlast_q          <= 1'b0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            seed_q           <= seed_d;
            beat_q           <= beat_d;
            tmo_q            <= tmo_d;
            pat_q            <= pat_d;
            busy_o           <= state_d inside {ST_AW, ST_W, ST_B, ST_AR, ST_R};
            done_o           <= (state_d == ST_DONE);
            err_cfg_o        <= err_cfg_d;
            err_resp_o       <= err_resp_d;
            err_proto_o      <= err_proto_d;
            timeout_o        <= timeout_d;
            mismatch_cnt_o   <= mis_d;
            first_bad_beat_o <= first_bad_d;
            awvalid_q        <= (state_d == ST_AW);
            wvalid_q         <= (state_d == ST_W);
            wlast_q          <= (state_d == ST_W) && (beat_d == req_d.len);
            bready_q         <= (state_d == ST_B);
            arvalid_q        <= (state_d == ST_AR);
            rready_q         <= (state_d == ST_R);
        end
    end

    assign m00_axi.awid    = AXI_ID;
    assign m00_axi.awaddr  = req_q.addr;
    assign m00_axi.awlen   = req_q.len;
    assign m00_axi.awsize  = AXI_SIZE_64B;
    assign m00_axi.awburst = AXI_BURST_INCR;
    assign m00_axi.awlock  = 1'b0;
    assign m00_axi.awcache = AXI_CACHE_DEFAULT;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awqos   = 4'h0;
    assign m00_axi.awuser  = 32'h0;
    assign m00_axi.awvalid = awvalid_q;

    assign m00_axi.wdata   = pat_q;
    assign m00_axi.wstrb   = '1;
    assign m00_axi.wlast   = wlast_q;
    assign m00_axi.wuser   = 64'h0;
    assign m00_axi.wvalid  = wvalid_q;

    assign m00_axi.bready  = bready_q;

    assign m00_axi.arid    = AXI_ID;
    assign m00_axi.araddr  = req_q.addr;
    assign m00_axi.arlen   = req_q.len;
    assign m00_axi.arsize  = AXI_SIZE_64B;
    assign m00_axi.arburst = AXI_BURST_INCR;
    assign m00_axi.arlock  = 1'b0;
    assign m00_axi.arcache = AXI_CACHE_DEFAULT;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arqos   = 4'h0;
    assign m00_axi.aruser  = 32'h0;
    assign m00_axi.arvalid = arvalid_q;

    assign m00_axi.rready  = rready_q;

endmodule

// File: tb/tb_hbm_axi_traffic_master.sv
// Randomised bench: behavioural AXI slave plus expected-result model for the traffic master.
module tb_hbm_axi_traffic_master;
    import hbm_tg_pkg::*;

    logic        aclk_0 = 1'b0;
    logic        aresetn_0;
    logic        start_i;
    logic [63:0] base_addr_i;
    logic [8:0]  num_beats_i;
    logic [31:0] seed_i;
    logic        busy_o, done_o, err_cfg_o, err_resp_o, err_proto_o, timeout_o;
    logic [15:0] mismatch_cnt_o;
    logic [7:0]  first_bad_beat_o;

    int total = 0;
    int bad   = 0;

    always #5 aclk_0 = ~aclk_0;

    hbm_axi_traffic_master_if axi ();

    hbm_axi_traffic_master #(
        .AXI_ID         (4'h0),
        .MAX_BEATS      (64),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .aclk_0           (aclk_0),
        .aresetn_0        (aresetn_0),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .num_beats_i      (num_beats_i),
        .seed_i           (seed_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_cfg_o        (err_cfg_o),
        .err_resp_o       (err_resp_o),
        .err_proto_o      (err_proto_o),
        .timeout_o        (timeout_o),
        .mismatch_cnt_o   (mismatch_cnt_o),
        .first_bad_beat_o (first_bad_beat_o),
        .m00_axi          (axi)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] seed, input int i);
        logic [31:0] w;
        w = seed + 32'(i);
        return {16{w}};
    endfunction

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, 512'({busy_o, done_o, err_cfg_o, err_resp_o, err_proto_o, timeout_o}), 512'(0));
        chk({tag, "_stat"}, 512'({mismatch_cnt_o, first_bad_beat_o}), 512'({16'h0, 8'hFF}));
        chk({tag, "_axi"}, 512'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 512'(0));
    endtask

    // One start command served by the slave model; expectations come from the arguments alone
    task automatic run(input logic [63:0] base, input int n, input logic [31:0] seed, input bit bp,
                       input int bad_beat, input bit b_err, input bit r0_err, input int early_last,
                       input int hold_aw, input int rst_at_w);
        logic [63:0]  exp_addr;
        bit           cfg_bad, done_seen, axi_seen, b_sent, did_rst, tmo_seen;
        bit           aw_stall, w_stall, ar_stall;
        int           aw_n, w_n, ar_n, r_n, done_cyc, tmo_wait, hold, budget;
        logic [63:0]  awaddr_r, araddr_r, aw_a, ar_a;
        logic [7:0]   awlen_r, arlen_r, aw_l, ar_l;
        logic [511:0] w_d;
        logic         w_l;
        exp_addr = {base[63:6], 6'b0};
        cfg_bad  = (n == 0) || (n > 64) || (int'(base[11:6]) + n > 64);
        {done_seen, axi_seen, b_sent, did_rst, tmo_seen, aw_stall, w_stall, ar_stall} = '0;
        {aw_n, w_n, ar_n, r_n, tmo_wait} = '0;
        done_cyc = -1; hold = hold_aw; budget = 6000 + 50 * n;
        awaddr_r = '1; araddr_r = '1; awlen_r = '0; arlen_r = '0;
        aw_a = '0; ar_a = '0; aw_l = '0; ar_l = '0; w_d = '0; w_l = 1'b0;

        @(negedge aclk_0);
        base_addr_i = base; num_beats_i = 9'(n); seed_i = seed; start_i = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge aclk_0);
            start_i = bp && (cyc > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            base_addr_i = {$urandom, $urandom}; seed_i = $urandom; num_beats_i = 9'($urandom_range(0, 80));
            if (axi.awvalid || axi.arvalid) axi_seen = 1'b1;
            if (done_o) begin
                done_seen = 1'b1; done_cyc = cyc;
                break;
            end
            if (timeout_o && !tmo_seen) begin
                tmo_seen = 1'b1;
                chk("tmo_in_aw", 512'({busy_o, axi.awvalid, axi.wvalid}), 512'(3'b110));
            end
            if (axi.awvalid && !timeout_o) tmo_wait++;
            if (aw_stall) chk("aw_hold", 512'({axi.awvalid, axi.awlen, axi.awaddr}), 512'({1'b1, aw_l, aw_a}));
            if (w_stall) begin
                chk("w_hold_ctl", 512'({axi.wvalid, axi.wlast}), 512'({1'b1, w_l}));
                chk("w_hold_data", axi.wdata, w_d);
            end
            if (ar_stall) chk("ar_hold", 512'({axi.arvalid, axi.arlen, axi.araddr}), 512'({1'b1, ar_l, ar_a}));
            if (rst_at_w >= 0 && w_n == rst_at_w) begin
                aresetn_0 = 1'b0; did_rst = 1'b1;
                slave_idle();
                break;
            end
            // AW channel
            if (hold > 0) begin
                axi.awready = 1'b0; hold--;
            end else begin
                axi.awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (axi.awvalid && axi.awready) begin
                aw_n++; awaddr_r = axi.awaddr; awlen_r = axi.awlen;
                chk("aw_attr", 512'({axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                                     axi.awprot, axi.awqos, axi.awuser}),
                    512'({4'h0, 3'b110, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 32'h0}));
            end
            aw_stall = axi.awvalid && !axi.awready; aw_a = axi.awaddr; aw_l = axi.awlen;
            // B channel, only after every W beat has been accepted
            axi.bvalid = (w_n == n) && !b_sent;
            axi.bid    = 4'h0;
            axi.bresp  = b_err ? 2'b10 : 2'b00;
            if (axi.bvalid && axi.bready) b_sent = 1'b1;
            // W channel
            axi.wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.wvalid && axi.wready) begin
                chk("w_order", 512'(aw_n), 512'(1));
                chk("wdata", axi.wdata, pat(seed, w_n));
                chk("wlast", 512'(axi.wlast), 512'(w_n == n - 1));
                chk("w_attr", 512'({axi.wstrb, axi.wuser}), 512'({64'hFFFF_FFFF_FFFF_FFFF, 64'h0}));
                w_n++;
            end
            w_stall = axi.wvalid && !axi.wready; w_d = axi.wdata; w_l = axi.wlast;
            // R channel, only after the AR handshake
            if (ar_n > 0 && r_n < n) begin
                axi.rvalid = 1'b1;
                axi.rid    = 4'h0;
                axi.rdata  = pat(seed, r_n) ^ ((r_n == bad_beat) ? 512'h1 : 512'h0);
                axi.rresp  = (r0_err && r_n == 0) ? 2'b10 : 2'b00;
                axi.rlast  = (early_last >= 0) ? (r_n == early_last) : (r_n == n - 1);
                if (axi.rready) r_n++;
            end else begin
                axi.rvalid = 1'b0; axi.rlast = 1'b0;
            end
            // AR channel
            axi.arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.arvalid && axi.arready) begin
                ar_n++; araddr_r = axi.araddr; arlen_r = axi.arlen;
                chk("ar_order", 512'(b_sent), 512'(1));
            end
            ar_stall = axi.arvalid && !axi.arready; ar_a = axi.araddr; ar_l = axi.arlen;
        end
        start_i = 1'b0;
        slave_idle();

        if (did_rst) begin
            @(negedge aclk_0);
            chk_reset("rst_mid");
            aresetn_0 = 1'b1;
            return;
        end
        chk("done_seen", 512'(done_seen), 512'(1));
        chk("busy_at_done", 512'(busy_o), 512'(0));
        chk("err_cfg", 512'(err_cfg_o), 512'(cfg_bad));
        chk("err_resp", 512'(err_resp_o), 512'(!cfg_bad && (b_err || r0_err)));
        chk("err_proto", 512'(err_proto_o), 512'(!cfg_bad && early_last >= 0 && early_last != n - 1));
        chk("timeout", 512'(timeout_o), 512'(!cfg_bad && hold_aw >= 4096));
        if (!cfg_bad && bad_beat >= 0 && bad_beat < n) begin
            chk("mis_cnt", 512'(mismatch_cnt_o), 512'(1));
            chk("first_bad", 512'(first_bad_beat_o), 512'(bad_beat));
        end else begin
            chk("mis_cnt", 512'(mismatch_cnt_o), 512'(0));
            chk("first_bad", 512'(first_bad_beat_o), 512'(8'hFF));
        end
        if (cfg_bad) begin
            chk("cfg_no_axi", 512'(axi_seen), 512'(0));
            chk("cfg_latency", 512'(done_cyc >= 1 && done_cyc <= 3), 512'(1));
        end else begin
            chk("aw_cnt", 512'(aw_n), 512'(1));
            chk("ar_cnt", 512'(ar_n), 512'(1));
            chk("awaddr", 512'(awaddr_r), 512'(exp_addr));
            chk("araddr", 512'(araddr_r), 512'(exp_addr));
            chk("awlen", 512'(awlen_r), 512'(n - 1));
            chk("arlen", 512'(arlen_r), 512'(n - 1));
            chk("w_beats", 512'(w_n), 512'(n));
            chk("r_beats", 512'(r_n), 512'(n));
            chk("b_done", 512'(b_sent), 512'(1));
            if (hold_aw >= 4096) chk("tmo_cycles", 512'(tmo_wait), 512'(4096));
        end
        @(negedge aclk_0);
        chk("done_pulse", 512'({done_o, busy_o}), 512'(0));
    endtask

    initial begin
        int n, off, bb, el;
        logic [63:0] b;
        aresetn_0 = 1'b0; start_i = 1'b0;
        base_addr_i = '0; num_beats_i = '0; seed_i = '0;
        slave_idle();
        repeat (3) @(negedge aclk_0);
        chk_reset("rst");
        aresetn_0 = 1'b1;

        run(64'h1000, 16, 32'hA5A5_0000, 1'b0, -1, 1'b0, 1'b0, -1, 0, -1);
        run(64'h1000, 16, 32'h1234_5678, 1'b0,  5, 1'b0, 1'b0, -1, 0, -1);
        run(64'h2000,  0, 32'h0000_0001, 1'b0, -1, 1'b0, 1'b0, -1, 0, -1);
        run(64'h2000, 65, 32'h0000_0002, 1'b0, -1, 1'b0, 1'b0, -1, 0, -1);
        run(64'h0FC0,  2, 32'h0000_0003, 1'b0, -1, 1'b0, 1'b0, -1, 0, -1);
        run(64'h3000,  8, 32'hFFFF_FFFC, 1'b0, -1, 1'b1, 1'b1, -1, 0, -1);
        run(64'h4000,  8, 32'hDEAD_BEEF, 1'b1, -1, 1'b0, 1'b0,  3, 0, -1);
        run(64'h0FC0,  1, 32'h0BAD_F00D, 1'b1, -1, 1'b0, 1'b0, -1, 0, -1);
        run(64'h5000,  4, 32'h5555_AAAA, 1'b0, -1, 1'b0, 1'b0, -1, 5000, -1);
        run(64'h6000, 16, 32'h7777_0000, 1'b0, -1, 1'b0, 1'b0, -1, 0, 5);
        run(64'h6000, 64, 32'h0101_0101, 1'b1, 63, 1'b0, 1'b0, -1, 0, -1);

        for (int t = 0; t < 10; t++) begin
            b   = {$urandom, $urandom};
            off = int'(b[11:6]);
            n   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(1, 64 - off);
            bb  = ($urandom_range(0, 1) == 1 && n > 0) ? $urandom_range(0, n - 1) : -1;
            el  = ($urandom_range(0, 2) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            run(b, n, $urandom, 1'($urandom_range(0, 1)), bb, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), el, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
